inv_key_schedule: RTL and testbench
===================================

INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit: load key_in and begin expansion; honoured only in IDLE.
REQ-005 SHALL have port key_in, input, 80 bits: master (round-1) key register, sampled when start is accepted.
REQ-006 SHALL have port next, input, 1 bit: consumer request for the next (lower-round) key.
REQ-007 SHALL have port key_out, output, 80 bits: current key register K_r.
REQ-008 SHALL have port round_out, output, 6 bits: index r of key_out, 1..32.
REQ-009 SHALL have port key_valid, output, 1 bit: high while key_out/round_out are valid.
REQ-010 SHALL have port busy, output, 1 bit: high in any state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after round 1 is consumed.

Function
REQ-012 SHALL implement forward step F(K,i), i=1..31: T=ROL13(K)={K[66:0],K[79:67]}; T[3:0]=S(T[3:0]); T[63:59]^=i[4:0]; K_(i+1)=F(K_i,i).
REQ-013 SHALL use S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 for inputs 0..F.
REQ-014 SHALL implement inverse step G(K,i): U=K; U[63:59]^=i[4:0]; U[3:0]=Sinv(U[3:0]); result={U[12:0],U[79:13]}; G(F(K,i),i)=K for every K, i.
REQ-015 SHALL use Sinv = 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A for inputs 0..F.
REQ-016 SHALL have states IDLE, EXPAND, OUTPUT.
REQ-017 IDLE: start=1 -> K<=key_in, cnt<=1, go EXPAND; otherwise hold.
REQ-018 EXPAND: each cycle K<=F(K,cnt), cnt<=cnt+1; on the cycle cnt=31, round<=32 and go OUTPUT. EXPAND lasts exactly 31 cycles.
REQ-019 OUTPUT: key_valid=1, key_out=K, round_out=round.
REQ-020 In OUTPUT with next=1 and round>1, SHALL set K<=G(K,round-1) and round<=round-1; new key visible the following cycle; key_valid stays high.
REQ-021 In OUTPUT with next=1 and round=1, SHALL go IDLE and pulse done for the following cycle; key_valid low in that cycle.
REQ-022 In OUTPUT with next=0, SHALL hold K and round indefinitely.
REQ-023 SHALL ignore start outside IDLE and next outside OUTPUT.
REQ-024 Latency start->first key_valid SHALL be 32 cycles (1 load + 31 expand); back-to-back next SHALL deliver one key per cycle.
REQ-025 In IDLE, key_out and round_out SHALL hold their last values; key_valid=0.

Reset
REQ-026 rst=1 at any edge, including mid-EXPAND or mid-OUTPUT, SHALL force IDLE, K=0, round=0, cnt=0, key_out=0, round_out=0, key_valid=0, busy=0, done=0; rst has priority over start and next.
REQ-027 start held high during reset SHALL NOT be accepted until the first edge with rst=0.

Verification
REQ-028 key_in=0, start, hold next=0 -> key_valid rises exactly 32 cycles after start; round_out=32; key_out equals reference-model F chain of K_1=0.
REQ-029 key_in=0, pulse next 30 times -> round_out=2, key_out=0x0000080000000000000C; one more next -> round_out=1, key_out=0; one more next -> done pulse, busy=0.
REQ-030 Random key_in, next held high continuously -> 32 consecutive keys, round_out 32..1, each equal to forward model K_r; done one cycle after round 1.
REQ-031 Random key_in, next toggled randomly -> sequence of key_out values identical to REQ-030 at each accepted next; key_out stable while next=0.
REQ-032 rst asserted at cycle 10 of EXPAND and again at round_out=17 -> all outputs 0 next cycle; fresh start then completes correctly.
REQ-033 start pulsed during EXPAND and OUTPUT, next pulsed during IDLE/EXPAND -> no effect on sequence or timing.

Source files
------------

// File: rtl/inv_key_schedule.sv
// Key schedule that runs forward to the last round key, then walks back
// down to round 1 one key per consumer request using the inverse step.
module inv_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] key_in,
    input  logic        next,
    output logic [79:0] key_out,
    output logic [5:0]  round_out,
    output logic        key_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, EXPAND, OUTPUT} state_t;

    state_t      state;
    logic [79:0] k;
    logic [5:0]  rnd;
    logic [4:0]  cnt;
    logic [4:0]  step_idx;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        case (x)
            4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
            4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
            4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
            4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
        endcase
    endfunction

    // Forward step: rotate left 13, substitute low nibble, mix in round index.
    function automatic logic [79:0] fwd_step(input logic [79:0] kin, input logic [4:0] i);
        logic [79:0] t;
        t         = {kin[66:0], kin[79:67]};
        t[3:0]    = sbox(t[3:0]);
        t[63:59]  = t[63:59] ^ i;
        fwd_step  = t;
    endfunction

    // Inverse step: undo the index mix and substitution, then rotate right 13.
    function automatic logic [79:0] inv_step(input logic [79:0] kin, input logic [4:0] i);
        logic [79:0] u;
        u         = kin;
        u[63:59]  = u[63:59] ^ i;
        u[3:0]    = sbox_inv(u[3:0]);
        inv_step  = {u[12:0], u[79:13]};
    endfunction

    // Stepping back from round r to r-1 uses the index that produced round r.
    assign step_idx = 5'(rnd - 6'd1);

    // Control FSM plus key/round registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            rnd   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k     <= key_in;
                        cnt   <= 5'd1;
                        state <= EXPAND;
                    end
                end
                EXPAND: begin
                    k   <= fwd_step(k, cnt);
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        rnd   <= 6'd32;
                        state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (next) begin
                        if (rnd > 6'd1) begin
                            k   <= inv_step(k, step_idx);
                            rnd <= rnd - 6'd1;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign key_out   = k;
    assign round_out = rnd;
    assign key_valid = (state == OUTPUT);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule: vector table plus multi-cycle sequences.
module tb_inv_key_schedule;

    logic        clk = 1'b0;
    logic        rst, start, next;
    logic [79:0] key_in;
    logic [79:0] key_out;
    logic [5:0]  round_out;
    logic        key_valid, busy, done;

    int total = 0;
    int passed = 0;

    logic [79:0] refk [1:32];
    logic [3:0]  sb [16] = '{4'hC,4'h5,4'h6,4'hB,4'h9,4'h0,4'hA,4'hD,
                             4'h3,4'hE,4'hF,4'h8,4'h4,4'h7,4'h1,4'h2};

    typedef struct {
        logic [79:0] key;
        int          nexts;
        logic [5:0]  exp_round;
        logic [79:0] exp_key;
    } vec_t;

    inv_key_schedule dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .next(next),
        .key_out(key_out), .round_out(round_out), .key_valid(key_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [79:0] fmodel(input logic [79:0] kin, input int i);
        logic [79:0] t;
        logic [4:0]  iv;
        iv       = i[4:0];
        t        = (kin << 13) | (kin >> 67);
        t[3:0]   = sb[t[3:0]];
        t[63:59] = t[63:59] ^ iv;
        return t;
    endfunction

    task automatic build_ref(input logic [79:0] kin);
        refk[1] = kin;
        for (int i = 1; i <= 31; i++) refk[i+1] = fmodel(refk[i], i);
    endtask

    task automatic check_zero(input string nm);
        check({nm, " key_out"},   key_out, 80'h0);
        check({nm, " round_out"}, 80'(round_out), 80'h0);
        check({nm, " flags"},     80'({key_valid, busy, done}), 80'h0);
    endtask

    // Start from IDLE and wait for the first valid key; checks latency.
    task automatic start_and_wait(input logic [79:0] kin);
        int n;
        key_in = kin;
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        n = 1;
        while (!key_valid && n < 100) begin
            cyc();
            n++;
        end
        check("latency", 80'(n), 80'd32);
    endtask

    // Hold next high and check every key on its way down, then done.
    task automatic drain_continuous(input string nm);
        check({nm, " r32 round"}, 80'(round_out), 80'd32);
        check({nm, " r32 key"},   key_out, refk[32]);
        next = 1'b1;
        for (int r = 31; r >= 1; r--) begin
            cyc();
            if (round_out !== 6'(r) || key_out !== refk[r] || !key_valid) begin
                check({nm, " chain round"}, 80'(round_out), 80'(r));
                check({nm, " chain key"},   key_out, refk[r]);
            end
        end
        check({nm, " r1 key"}, key_out, refk[1]);
        cyc();
        next = 1'b0;
        check({nm, " done pulse"}, 80'({done, key_valid, busy}), 80'b100);
        cyc();
        check({nm, " done low"}, 80'(done), 80'd0);
        check({nm, " idle hold round"}, 80'(round_out), 80'd1);
    endtask

    initial begin
        vec_t vt [4];
        int   n;
        logic [5:0] er;

        vt[0] = '{80'h0, 30, 6'd2, 80'h0000080000000000000C};
        vt[1] = '{80'h0, 31, 6'd1, 80'h0};
        vt[2] = '{80'h1, 30, 6'd2, 80'h0000080000000000200C};
        vt[3] = '{80'hFFFFFFFFFFFFFFFFFFFF, 30, 6'd2, 80'hFFFFF7FFFFFFFFFFFFF2};

        rst = 1'b1; start = 1'b0; next = 1'b0; key_in = '0;
        cyc(); cyc();
        check_zero("reset");
        rst = 1'b0;

        // Key 0: first key is round 32 of the forward chain.
        build_ref(80'h0);
        start_and_wait(80'h0);
        check("k0 round32", 80'(round_out), 80'd32);
        check("k0 key32", key_out, refk[32]);
        rst = 1'b1; cyc(); rst = 1'b0;

        // Vector table: walk down a fixed number of rounds.
        for (int v = 0; v < 4; v++) begin
            start_and_wait(vt[v].key);
            for (int j = 0; j < vt[v].nexts; j++) begin
                next = 1'b1; cyc(); next = 1'b0; cyc();
            end
            check($sformatf("vec%0d round", v), 80'(round_out), 80'(vt[v].exp_round));
            check($sformatf("vec%0d key", v), key_out, vt[v].exp_key);
            n = 0;
            while (!done && n < 80) begin
                next = 1'b1; cyc(); n++;
            end
            next = 1'b0;
            check($sformatf("vec%0d done", v), 80'({done, busy}), 80'b10);
            cyc();
        end

        // Random key with next held high.
        key_in = {$urandom(), $urandom(), 16'($urandom())};
        build_ref(key_in);
        start_and_wait(key_in);
        drain_continuous("cont");

        // Same key with next toggled randomly; key must hold while next=0.
        start_and_wait(refk[1]);
        er = 6'd32;
        n = 0;
        while (n < 600) begin
            next = 1'($urandom_range(0, 1));
            cyc();
            n++;
            if (next && er == 6'd1) break;
            if (next) er = er - 6'd1;
            if (round_out !== er || key_out !== refk[er]) begin
                check("toggle round", 80'(round_out), 80'(er));
                check("toggle key", key_out, refk[er]);
            end
        end
        next = 1'b0;
        check("toggle done", 80'({done, busy}), 80'b10);
        cyc();

        // Reset in the middle of EXPAND.
        key_in = 80'h0123456789ABCDEF0123;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 9; i++) cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        check_zero("rst expand");

        // Reset at round 17.
        start_and_wait(key_in);
        for (int i = 0; i < 15; i++) begin
            next = 1'b1; cyc();
        end
        next = 1'b0;
        check("pre-rst round", 80'(round_out), 80'd17);
        rst = 1'b1; cyc(); rst = 1'b0;
        check_zero("rst output");

        // Fresh run after reset completes correctly.
        build_ref(key_in);
        start_and_wait(key_in);
        drain_continuous("fresh");

        // next in IDLE is ignored.
        next = 1'b1; cyc(); cyc(); next = 1'b0;
        check("idle next", 80'({busy, key_valid, done}), 80'b000);

        // start/next during EXPAND and start during OUTPUT are ignored.
        key_in = 80'hA5A5_0F0F_3C3C_9696_FFFF;
        build_ref(key_in);
        start = 1'b1; cyc(); start = 1'b0;
        key_in = 80'h0;
        n = 1;
        while (!key_valid && n < 100) begin
            start = (n >= 4 && n <= 8);
            next  = (n >= 2 && n <= 20);
            cyc();
            n++;
        end
        start = 1'b0; next = 1'b0;
        check("noisy latency", 80'(n), 80'd32);
        start = 1'b1; key_in = 80'h1; cyc(); cyc(); start = 1'b0;
        check("output start round", 80'(round_out), 80'd32);
        check("output start key", key_out, refk[32]);
        drain_continuous("noisy");

        // start held through reset is taken only once rst drops.
        rst = 1'b1; start = 1'b1; key_in = refk[1];
        cyc(); cyc();
        check("start in rst", 80'(busy), 80'd0);
        rst = 1'b0;
        cyc();
        start = 1'b0;
        check("start after rst", 80'(busy), 80'd1);
        n = 1;
        while (!key_valid && n < 100) begin
            cyc();
            n++;
        end
        check("post-rst latency", 80'(n), 80'd32);
        check("post-rst key", key_out, refk[32]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
